// File: rtl/rcon_sequencer.sv
// AES key-schedule round-constant engine: walks Rcon forward (xtime) or backward (inverse xtime)
// and applies it to one byte lane of each key word through a single-entry valid/ready stage.
module rcon_sequencer #(
    parameter int WORD_W = 32,
    parameter int LANE   = 3,
    parameter int XOR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [1:0]        key_len_in,
    input  logic              dir_in,
    input  logic [WORD_W-1:0] word_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    output logic [WORD_W-1:0] word_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [7:0]        rcon_out,
    output logic [3:0]        round_idx_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Exact inverse of xtime: undo the reduction, then shift the carry back into bit 7.
    function automatic logic [7:0] inv_xtime(input logic [7:0] y);
        logic [7:0] t;
        t = y ^ (y[0] ? 8'h1B : 8'h00);
        return (t >> 1) | {y[0], 7'b0000000};
    endfunction

    function automatic logic [WORD_W-1:0] apply_rcon(input logic [WORD_W-1:0] w,
                                                     input logic [7:0]        r);
        logic [WORD_W-1:0] sh;
        logic [WORD_W-1:0] mask;
        sh   = WORD_W'(r) << (8 * LANE);
        mask = WORD_W'(8'hFF) << (8 * LANE);
        if (XOR_EN != 0) begin
            return w ^ sh;
        end else begin
            return (w & ~mask) | sh;
        end
    endfunction

    logic [1:0]        state_q, state_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        n_q, n_d;
    logic              dir_q, dir_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept_s;
    logic              take_s;

    assign in_ready_out  = (state_q == S_RUN) && (!out_valid_q || out_ready_in);
    assign accept_s      = in_valid_in && in_ready_out;
    assign take_s        = out_valid_q && out_ready_in;
    assign word_out      = word_q;
    assign out_valid_out = out_valid_q;
    assign rcon_out      = rcon_q;
    assign round_idx_out = cnt_q;
    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = done_q;
    assign err_out       = err_q;

    // Next-state, Rcon stepping and output-stage update.
    always_comb begin
        state_d     = state_q;
        rcon_d      = rcon_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        dir_d       = dir_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (key_len_in == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = 4'd0;
                        dir_d   = dir_in;
                        case (key_len_in)
                            2'b00:   begin n_d = 4'd10; rcon_d = dir_in ? 8'h36 : 8'h01; end
                            2'b01:   begin n_d = 4'd8;  rcon_d = dir_in ? 8'h80 : 8'h01; end
                            default: begin n_d = 4'd7;  rcon_d = dir_in ? 8'h40 : 8'h01; end
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    word_d      = apply_rcon(word_in, rcon_q);
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    rcon_d      = dir_q ? inv_xtime(rcon_q) : xtime(rcon_q);
                    if (cnt_q == n_q - 4'd1) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (take_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            S_DRAIN: begin
                if (take_s) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    rcon_d      = 8'h00;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                rcon_d      = 8'h00;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rcon_q      <= 8'h00;
            cnt_q       <= 4'd0;
            n_q         <= 4'd0;
            dir_q       <= 1'b0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcon_q      <= rcon_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            dir_q       <= dir_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_rcon_sequencer.sv
// Scoreboard bench for rcon_sequencer (WORD_W=32, LANE=3, XOR_EN=1).
module tb_rcon_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [1:0]  key_len_in;
    logic        dir_in;
    logic [31:0] word_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [31:0] word_out;
    logic        out_valid_out;
    logic        out_ready_in;
    logic [7:0]  rcon_out;
    logic [3:0]  round_idx_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  enc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    rcon_sequencer #(.WORD_W(32), .LANE(3), .XOR_EN(1)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .key_len_in(key_len_in),
        .dir_in(dir_in), .word_in(word_in), .in_valid_in(in_valid_in),
        .in_ready_out(in_ready_out), .word_out(word_out), .out_valid_out(out_valid_out),
        .out_ready_in(out_ready_in), .rcon_out(rcon_out), .round_idx_out(round_idx_out),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input logic [1:0] kl);
        return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 8 : 7;
    endfunction

    function automatic logic [7:0] exp_rcon(input logic [1:0] kl, input logic dir, input int i);
        return dir ? enc_tab[n_of(kl) - 1 - i] : enc_tab[i];
    endfunction

    // Output monitor: pop one expected word per output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_out && out_ready_in) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", word_out, 32'hDEAD_BEEF);
                end else begin
                    check_eq("word_out", word_out, exp_q.pop_front());
                end
            end
            if (done_out) done_cnt++;
            if (err_out) err_cnt++;
        end
    end

    // Runs one sequence; feeds nwords words (full sequence when nwords == N).
    task automatic run_seq(input logic [1:0] kl, input logic dir, input logic [31:0] w,
                           input int nwords, input int stall_at, input bit poke);
        int n;
        int waited;
        int done_before;
        logic [31:0] held;
        n = n_of(kl);
        done_before = done_cnt;
        @(posedge clk); #1;
        start_in = 1'b1; key_len_in = kl; dir_in = dir;
        @(posedge clk); #1;
        start_in = 1'b0;
        check_eq("busy_after_start", {31'd0, busy_out}, 32'd1);
        for (int i = 0; i < nwords; i++) begin
            in_valid_in = 1'b1;
            word_in = w;
            waited = 0;
            @(negedge clk);
            while (!in_ready_out && waited < 50) begin
                waited++;
                @(negedge clk);
            end
            check_eq("ready_timeout", {31'd0, in_ready_out}, 32'd1);
            check_eq("rcon_out", {24'd0, rcon_out}, {24'd0, exp_rcon(kl, dir, i)});
            check_eq("round_idx", {28'd0, round_idx_out}, i);
            exp_q.push_back(w ^ {exp_rcon(kl, dir, i), 24'h000000});
            @(posedge clk); #1;
            in_valid_in = 1'b0;
            start_in = poke && (i == 2);
            key_len_in = poke ? 2'b11 : kl;
            if (i == stall_at) begin
                out_ready_in = 1'b0;
                in_valid_in = 1'b1;
                @(negedge clk);
                held = word_out;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check_eq("stall_word", word_out, held);
                    check_eq("stall_ready", {31'd0, in_ready_out}, 32'd0);
                    check_eq("stall_valid", {31'd0, out_valid_out}, 32'd1);
                end
                @(posedge clk); #1;
                out_ready_in = 1'b1;
            end
            start_in = 1'b0;
        end
        in_valid_in = 1'b0;
        if (nwords == n) begin
            waited = 0;
            @(negedge clk);
            while (!done_out && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            check_eq("done_seen", {31'd0, done_out}, 32'd1);
            @(negedge clk);
            check_eq("done_once", done_cnt - done_before, 32'd1);
            check_eq("idle_busy", {31'd0, busy_out}, 32'd0);
            check_eq("idle_rcon", {24'd0, rcon_out}, 32'd0);
            check_eq("idle_idx", {28'd0, round_idx_out}, n);
            check_eq("queue_empty", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; key_len_in = 2'b00; dir_in = 1'b0;
        word_in = 32'd0; in_valid_in = 1'b0; out_ready_in = 1'b1;
        #1;
        check_eq("rst_valid", {31'd0, out_valid_out}, 32'd0);
        check_eq("rst_word", word_out, 32'd0);
        check_eq("rst_rcon", {24'd0, rcon_out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // T1/T2/T3: sequences for each length and direction.
        run_seq(2'b00, 1'b0, 32'h0000_0000, 10, -1, 1'b0);
        run_seq(2'b00, 1'b1, 32'h0000_0000, 10, -1, 1'b0);
        run_seq(2'b10, 1'b1, 32'h0000_0000, 7, -1, 1'b0);
        run_seq(2'b01, 1'b0, 32'hFFFF_FFFF, 8, -1, 1'b0);
        run_seq(2'b01, 1'b1, 32'h1234_5678, 8, -1, 1'b0);
        // T4: output stall mid-run.
        run_seq(2'b10, 1'b0, 32'hA5A5_5A5A, 7, 3, 1'b0);

        // T5: illegal key length, then start pokes during RUN.
        @(posedge clk); #1;
        start_in = 1'b1; key_len_in = 2'b11;
        @(posedge clk); #1;
        start_in = 1'b0; key_len_in = 2'b00;
        check_eq("err_pulse", {31'd0, err_out}, 32'd1);
        check_eq("err_busy", {31'd0, busy_out}, 32'd0);
        @(posedge clk); #1;
        check_eq("err_clear", {31'd0, err_out}, 32'd0);
        check_eq("err_idle", {31'd0, busy_out}, 32'd0);
        run_seq(2'b00, 1'b0, 32'h0F0F_0F0F, 10, -1, 1'b1);
        check_eq("err_count", err_cnt, 32'd1);

        // T6: reset after 4 accepts, then restart.
        run_seq(2'b00, 1'b0, 32'h0000_0000, 4, -1, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid_out}, 32'd0);
        check_eq("mid_rst_word", word_out, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        check_eq("mid_rst_rcon", {24'd0, rcon_out}, 32'd0);
        check_eq("mid_rst_idx", {28'd0, round_idx_out}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq(2'b00, 1'b0, 32'h0000_0000, 10, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
